// File: rtl/phoenix_led_pattern_controller.sv
// Multi-channel LED PWM controller: OFF/ON/BLINK/BREATHE patterns per channel,
// reconfigured through a valid/ready write port with a single pending slot.

module phoenix_led_channel #(
   parameter int unsigned W            = 32,
   parameter int unsigned PWM_CYCLE    = 25000,
   parameter int unsigned INIT_PERIOD  = 25000000,
   parameter int unsigned BREATHE_STEP = 500
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wrap_i,
   input  logic         apply_i,
   input  logic [1:0]   mode_i,
   input  logic [W-1:0] period_i,
   input  logic [W-1:0] cnt_i,
   output logic [W-1:0] duty_o,
   output logic         pwm_o
);

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_ON      = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_BREATHE = 2'd3
   } mode_e;

   localparam int unsigned  INIT_P = (INIT_PERIOD < 2) ? 2 : INIT_PERIOD;
   localparam logic [W-1:0] FULL   = W'(PWM_CYCLE);
   localparam logic [W-1:0] STEP   = W'(BREATHE_STEP);
   localparam logic [W-1:0] ONE    = W'(1);

   mode_e        mode_q, mode_d;
   logic [W-1:0] period_q, period_d;
   logic [W-1:0] phase_q, phase_d;
   logic [W-1:0] duty_q, duty_d;
   logic         down_q, down_d;
   logic         pwm_q;
   logic [W:0]   up_sum;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_q   <= MODE_BLINK;
         period_q <= W'(INIT_P);
         phase_q  <= '0;
         duty_q   <= '0;
         down_q   <= 1'b0;
         pwm_q    <= 1'b0;
      end else begin
         mode_q   <= mode_d;
         period_q <= period_d;
         phase_q  <= phase_d;
         duty_q   <= duty_d;
         down_q   <= down_d;
         pwm_q    <= (cnt_i < duty_q);
      end
   end

   always_comb begin
      mode_d   = mode_q;
      period_d = period_q;
      phase_d  = phase_q;
      duty_d   = duty_q;
      down_d   = down_q;
      // One extra bit so the upward step can never wrap past FULL.
      up_sum   = {1'b0, duty_q} + {1'b0, STEP};
      if (apply_i) begin
         mode_d   = mode_e'(mode_i);
         period_d = period_i;
         phase_d  = '0;
         down_d   = 1'b0;
         duty_d   = (mode_e'(mode_i) == MODE_ON) ? FULL : '0;
      end else begin
         case (mode_q)
            MODE_OFF: duty_d = '0;
            MODE_ON:  duty_d = FULL;
            MODE_BLINK: begin
               phase_d = (phase_q >= period_q - ONE) ? '0 : phase_q + ONE;
               duty_d  = (phase_q >= (period_q >> 1)) ? FULL : '0;
            end
            MODE_BREATHE: begin
               if (wrap_i) begin
                  if (!down_q) begin
                     if (up_sum >= {1'b0, FULL}) begin
                        duty_d = FULL;
                        down_d = 1'b1;
                     end else begin
                        duty_d = up_sum[W-1:0];
                     end
                  end else begin
                     if (duty_q <= STEP) begin
                        duty_d = '0;
                        down_d = 1'b0;
                     end else begin
                        duty_d = duty_q - STEP;
                     end
                  end
               end
            end
            default: duty_d = duty_q;
         endcase
      end
   end

   assign duty_o = duty_q;
   assign pwm_o  = pwm_q;

endmodule

module phoenix_led_pattern_controller #(
   parameter int unsigned CLOCK_FREQUENCY  = 25_000_000,
   parameter int unsigned PWM_COUNTER_BITS = 32,
   parameter int unsigned PWM_CYCLE        = CLOCK_FREQUENCY / 1000,
   parameter int unsigned NUM_CHANNELS     = 4,
   parameter int unsigned INIT_BLINK_CYCLE = CLOCK_FREQUENCY,
   parameter int unsigned BREATHE_STEP     = PWM_CYCLE / 50
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 cfg_valid,
   output logic                                 cfg_ready,
   input  logic [3:0]                           cfg_channel,
   input  logic [1:0]                           cfg_mode,
   input  logic [PWM_COUNTER_BITS-1:0]          cfg_period,
   output logic                                 cfg_error,
   output logic [PWM_COUNTER_BITS-1:0]          pwm_cycle,
   output logic [NUM_CHANNELS*PWM_COUNTER_BITS-1:0] pwm_duty,
   output logic [NUM_CHANNELS-1:0]              pwm_out
);

   localparam int unsigned  W    = PWM_COUNTER_BITS;
   localparam logic [W-1:0] LAST = W'(PWM_CYCLE - 1);
   localparam logic [W-1:0] MINP = W'(2);

   typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_e;

   slot_e        slot_q, slot_d;
   logic [3:0]   pend_ch_q, pend_ch_d;
   logic [1:0]   pend_mode_q, pend_mode_d;
   logic [W-1:0] pend_period_q, pend_period_d;
   logic         err_q, err_d;
   logic [W-1:0] cnt_q, cnt_d;
   logic         wrap, accept, ch_bad, apply;

   logic [NUM_CHANNELS-1:0][W-1:0] lane_duty;
   logic [NUM_CHANNELS-1:0]        lane_pwm;

   assign wrap      = (cnt_q == LAST);
   assign cnt_d     = wrap ? '0 : cnt_q + W'(1);
   assign cfg_ready = (slot_q == SLOT_EMPTY);
   assign accept    = cfg_valid && cfg_ready;
   assign ch_bad    = ({1'b0, cfg_channel} >= 5'(NUM_CHANNELS));
   assign apply     = (slot_q == SLOT_FULL) && wrap;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_q        <= SLOT_EMPTY;
         pend_ch_q     <= '0;
         pend_mode_q   <= '0;
         pend_period_q <= MINP;
         err_q         <= 1'b0;
         cnt_q         <= '0;
      end else begin
         slot_q        <= slot_d;
         pend_ch_q     <= pend_ch_d;
         pend_mode_q   <= pend_mode_d;
         pend_period_q <= pend_period_d;
         err_q         <= err_d;
         cnt_q         <= cnt_d;
      end
   end

   // A full slot blocks acceptance, so apply and capture never coincide.
   always_comb begin
      slot_d        = slot_q;
      pend_ch_d     = pend_ch_q;
      pend_mode_d   = pend_mode_q;
      pend_period_d = pend_period_q;
      err_d         = 1'b0;
      case (slot_q)
         SLOT_EMPTY: begin
            if (accept) begin
               if (ch_bad) begin
                  err_d = 1'b1;
               end else begin
                  slot_d        = SLOT_FULL;
                  pend_ch_d     = cfg_channel;
                  pend_mode_d   = cfg_mode;
                  pend_period_d = (cfg_period < MINP) ? MINP : cfg_period;
               end
            end
         end
         SLOT_FULL: begin
            if (wrap) slot_d = SLOT_EMPTY;
         end
         default: slot_d = SLOT_EMPTY;
      endcase
   end

   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_lane
      phoenix_led_channel #(
         .W            (W),
         .PWM_CYCLE    (PWM_CYCLE),
         .INIT_PERIOD  (INIT_BLINK_CYCLE),
         .BREATHE_STEP (BREATHE_STEP)
      ) u_ch (
         .clk      (clk),
         .reset    (reset),
         .wrap_i   (wrap),
         .apply_i  (apply && (pend_ch_q == 4'(i))),
         .mode_i   (pend_mode_q),
         .period_i (pend_period_q),
         .cnt_i    (cnt_q),
         .duty_o   (lane_duty[i]),
         .pwm_o    (lane_pwm[i])
      );
   end

   assign pwm_duty  = lane_duty;
   assign pwm_out   = lane_pwm;
   assign pwm_cycle = W'(PWM_CYCLE);
   assign cfg_error = err_q;

endmodule

// File: tb/tb_phoenix_led_pattern_controller.sv
// Bench for phoenix_led_pattern_controller: directed scenarios plus random writes,
// checked against a model that derives duties from edge/wrap counts since apply.

module tb_phoenix_led_pattern_controller;

   localparam int P    = 10;
   localparam int NC   = 2;
   localparam int W    = 32;
   localparam int INIT = 20;
   localparam int S    = 5;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              cfg_valid = 1'b0;
   logic              cfg_ready;
   logic [3:0]        cfg_channel = '0;
   logic [1:0]        cfg_mode = '0;
   logic [W-1:0]      cfg_period = '0;
   logic              cfg_error;
   logic [W-1:0]      pwm_cycle;
   logic [NC*W-1:0]   pwm_duty;
   logic [NC-1:0]     pwm_out;

   int total = 0;
   int bad   = 0;

   // model: mode/period per channel, edges (n) and wraps (k) since apply/reset
   int m_mode[NC], m_per[NC], m_n[NC], m_k[NC];
   bit m_pend, m_err;
   int m_pch, m_pmode, m_pper, m_cnt;

   phoenix_led_pattern_controller #(
      .CLOCK_FREQUENCY  (10000),
      .PWM_COUNTER_BITS (W),
      .PWM_CYCLE        (P),
      .NUM_CHANNELS     (NC),
      .INIT_BLINK_CYCLE (INIT),
      .BREATHE_STEP     (S)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_channel (cfg_channel),
      .cfg_mode    (cfg_mode),
      .cfg_period  (cfg_period),
      .cfg_error   (cfg_error),
      .pwm_cycle   (pwm_cycle),
      .pwm_duty    (pwm_duty),
      .pwm_out     (pwm_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int exp_duty(input int i);
      int t;
      case (m_mode[i])
         0: return 0;
         1: return P;
         2: begin
            if (m_n[i] == 0) return 0;
            return (((m_n[i] - 1) % m_per[i]) >= m_per[i] / 2) ? P : 0;
         end
         default: begin
            // triangle wave 0..P..0 advancing S per wrap
            t = (m_k[i] * S) % (2 * P);
            return (t <= P) ? t : 2 * P - t;
         end
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NC; i++) begin
         m_mode[i] = 2; m_per[i] = INIT; m_n[i] = 0; m_k[i] = 0;
      end
      m_pend = 0; m_err = 0; m_cnt = 0;
   endtask

   task automatic check_all();
      for (int i = 0; i < NC; i++)
         chk($sformatf("duty%0d", i), pwm_duty[i*W +: W], exp_duty(i));
      chk("ready", cfg_ready, !m_pend);
      chk("error", cfg_error, m_err);
      chk("cycle", pwm_cycle, P);
   endtask

   task automatic tick();
      logic [NC-1:0] exp_out;
      bit wrap, acc, app;
      int ch, md, pr;
      wrap = (m_cnt == P - 1);
      acc  = cfg_valid && !m_pend;
      app  = m_pend && wrap;
      ch = int'(cfg_channel); md = int'(cfg_mode); pr = int'(cfg_period);
      for (int i = 0; i < NC; i++) exp_out[i] = (m_cnt < exp_duty(i));
      @(posedge clk);
      for (int i = 0; i < NC; i++) begin
         if (app && m_pch == i) begin
            m_mode[i] = m_pmode; m_per[i] = m_pper; m_n[i] = 0; m_k[i] = 0;
         end else begin
            m_n[i]++;
            if (wrap) m_k[i]++;
         end
      end
      if (app) m_pend = 0;
      m_err = 0;
      if (acc) begin
         if (ch >= NC) m_err = 1;
         else begin
            m_pend = 1; m_pch = ch; m_pmode = md; m_pper = (pr < 2) ? 2 : pr;
         end
      end
      m_cnt = wrap ? 0 : m_cnt + 1;
      #1;
      check_all();
      chk("pwm_out", pwm_out, exp_out);
   endtask

   task automatic do_reset();
      cfg_valid = 1'b0;
      reset = 1'b1;
      #2;
      model_reset();
      check_all();
      chk("rst_pwm_out", pwm_out, '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic put(input int ch, input int md, input int pr);
      cfg_valid = 1'b1; cfg_channel = 4'(ch); cfg_mode = 2'(md); cfg_period = W'(pr);
   endtask

   initial begin
      #1;
      do_reset();
      repeat (45) tick();                             // reset blink pattern
      for (int g = 0; g < P && m_cnt != 3; g++) tick();
      put(1, 1, 0); tick(); cfg_valid = 1'b0;         // ch1 ON
      repeat (25) tick();
      put(0, 3, 0); tick(); cfg_valid = 1'b0;         // ch0 BREATHE
      repeat (70) tick();
      put(3, 1, 0); tick(); cfg_valid = 1'b0;         // bad channel
      repeat (5) tick();
      put(0, 2, 1); tick(); cfg_valid = 1'b0;         // BLINK period clamp
      repeat (30) tick();
      for (int g = 0; g < P && m_cnt != 1; g++) tick();
      put(1, 0, 0); tick(); cfg_valid = 1'b0;         // pending OFF then reset
      repeat (2) tick();
      chk("pend_before_rst", cfg_ready, 1'b0);
      do_reset();
      repeat (30) tick();
      repeat (800) begin
         cfg_valid   = ($urandom_range(0, 3) == 0);
         cfg_channel = 4'($urandom_range(0, 3));
         cfg_mode    = 2'($urandom_range(0, 3));
         cfg_period  = W'($urandom_range(0, 30));
         tick();
      end
      cfg_valid = 1'b0;
      repeat (20) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/phoenix_led_pattern_controller.md
PHOENIX_LED_PATTERN_CONTROLLER -- requirements
Module: phoenix_led_pattern_controller

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- CLOCK_FREQUENCY, 25_000_000, clk rate in Hz.
- PWM_COUNTER_BITS, 32, width of all counters, periods and duties.
- PWM_CYCLE, CLOCK_FREQUENCY*0.001, PWM period in clocks (>=2).
- NUM_CHANNELS, 4, independent LED channels (1..16).
- INIT_BLINK_CYCLE, CLOCK_FREQUENCY*1.0, blink period loaded at reset.
- BREATHE_STEP, PWM_CYCLE/50, duty change per PWM period in BREATHE mode (>=1).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- reset, in, 1, asynchronous, active-high reset.
- cfg_valid, in, 1, config write request.
- cfg_ready, out, 1, config write can be accepted.
- cfg_channel, in, 4, target channel index.
- cfg_mode, in, 2, 0=OFF 1=ON 2=BLINK 3=BREATHE.
- cfg_period, in, PWM_COUNTER_BITS, blink period in clocks.
- cfg_error, out, 1, one-cycle pulse: accepted write had out-of-range channel.
- pwm_cycle, out, PWM_COUNTER_BITS, PWM period (constant PWM_CYCLE).
- pwm_duty, out, NUM_CHANNELS*PWM_COUNTER_BITS, packed per-channel duty, channel i at bits [i*W +: W].
- pwm_out, out, NUM_CHANNELS, per-channel PWM waveform.

Function
REQ-003 A shared PWM counter SHALL count 0..PWM_CYCLE-1 and wrap to 0; the edge with counter==PWM_CYCLE-1 is the "wrap edge".
REQ-004 pwm_out[i] SHALL be registered as (pwm counter < duty[i]), one clock latency; duty==PWM_CYCLE gives constant high, duty==0 constant low.
REQ-005 Handshake: a write SHALL be accepted on an edge with cfg_valid && cfg_ready; it is then captured into a single pending slot and cfg_ready deasserts on the next cycle.
REQ-006 cfg_valid while cfg_ready is low SHALL be ignored; there is no queueing beyond the single pending slot.
REQ-007 A pending write SHALL be applied on the next wrap edge after capture (a write accepted on a wrap edge applies on the following wrap edge); cfg_ready reasserts the cycle after the apply.
REQ-008 On apply, the target channel SHALL load mode and period, clear phase, and set duty to PWM_CYCLE for ON and 0 for OFF/BLINK/BREATHE; BREATHE direction resets to up.
REQ-009 cfg_period < 2 SHALL be stored as 2; cfg_period is ignored except in BLINK.
REQ-010 cfg_channel >= NUM_CHANNELS SHALL be accepted per REQ-005, produce a one-cycle cfg_error pulse on the cycle after acceptance, and create no pending write (cfg_ready stays high).
REQ-011 BLINK: the per-channel phase SHALL increment every clock, wrapping from period-1 to 0; duty is registered as PWM_CYCLE when phase >= period>>1, else 0 (one clock latency from phase).
REQ-012 BREATHE: on each wrap edge, duty SHALL move by BREATHE_STEP in the current direction, saturating at PWM_CYCLE (direction -> down) and at 0 (direction -> up); no overflow or underflow.
REQ-013 OFF/ON: duty SHALL stay constant at 0 or PWM_CYCLE.
REQ-014 Channels SHALL be fully independent; apply affects only the addressed channel.

Reset
REQ-015 While reset is high, asynchronously: PWM counter 0, all phases 0, all duties 0, pwm_out 0, cfg_ready 1, cfg_error 0, pending slot cleared, every channel mode BLINK with period INIT_BLINK_CYCLE (min 2), BREATHE direction up, pwm_cycle = PWM_CYCLE.
REQ-016 Reset mid-operation SHALL discard any pending write without applying it.

Verification (PWM_CYCLE=10, NUM_CHANNELS=2, INIT_BLINK_CYCLE=20, BREATHE_STEP=5)
REQ-017 Reset release -> each pwm_duty lane is 0 for the first 10 edges, 10 from edge 11 to edge 20, then alternates every 10 clocks; pwm_cycle == 10 throughout.
REQ-018 Write ch1 ON when PWM counter==3 -> cfg_ready low from the next cycle; duty[1]=10 after the 9->0 wrap edge; pwm_out[1] constantly high one clock later; ch0 unaffected.
REQ-019 Write ch0 BREATHE -> after apply, duty[0] goes 0,5,10,5,0,5 on successive wrap edges.
REQ-020 Write cfg_channel=3 -> cfg_error high for exactly one cycle, cfg_ready never drops, no duty change.
REQ-021 Write ch0 BLINK period=1 -> period stored as 2; duty[0] toggles 0/10 every clock after apply.
REQ-022 Assert reset while a write is pending -> outputs take REQ-015 values without a clock edge; after release no channel shows the discarded mode.
